// File: rtl/wb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_sb (with qspa_pkg)
// Brief    : QSP writeback stage. Register file and flags commit, bypassed
//            decode read ports, and a per-register pending-write scoreboard.
// Revision : 1.0  initial release
// ============================================================================

package qspa_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

module wb_regfile_sb
    import qspa_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter bit R0_ZERO  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wb_alu_result,
    input  logic [3:0]            wb_rd_addr,
    input  logic                  wb_we,
    input  logic                  wb_flags_we,
    input  logic                  wb_flag_zero,
    input  logic                  wb_flag_carry,
    input  logic                  wb_flag_ovf,
    input  logic [3:0]            id_rs1_addr,
    input  logic [3:0]            id_rs2_addr,
    output logic [DATA_WIDTH-1:0] id_rs1_data,
    output logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic                  id_issue,
    input  logic                  id_issue_we,
    input  logic [3:0]            id_issue_rd,
    output logic [2:0]            id_flags,
    output logic                  hz_stall,
    output logic                  sb_overflow
);

    localparam logic [1:0] c_PEND_MAX = 2'd3;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [1:0]            r_pend [NUM_REGS];
    logic [2:0]            r_flags;
    logic                  r_sb_overflow;

    logic [NUM_REGS-1:0]   w_inc;
    logic [NUM_REGS-1:0]   w_dec;
    logic                  w_ovf_set;

    function automatic logic f_is_r0(input logic [3:0] a);
        return R0_ZERO && (a == 4'd0);
    endfunction

    // R0 is excluded from both counting and storage when it is hardwired zero.
    always_comb begin
        w_inc     = '0;
        w_dec     = '0;
        w_ovf_set = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!(R0_ZERO && r == 0)) begin
                w_inc[r] = id_issue && id_issue_we && (id_issue_rd == 4'(r));
                w_dec[r] = wb_we && (wb_rd_addr == 4'(r));
            end
            if (w_inc[r] && !w_dec[r] && (r_pend[r] == c_PEND_MAX)) begin
                w_ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
                r_pend[r] <= 2'd0;
            end
            r_flags       <= 3'b000;
            r_sb_overflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_dec[r]) begin
                    r_regs[r] <= wb_alu_result;
                end
                if (w_inc[r] && !w_dec[r]) begin
                    if (r_pend[r] != c_PEND_MAX) r_pend[r] <= r_pend[r] + 2'd1;
                end else if (w_dec[r] && !w_inc[r]) begin
                    if (r_pend[r] != 2'd0) r_pend[r] <= r_pend[r] - 2'd1;
                end
            end
            if (wb_flags_we) begin
                r_flags <= {wb_flag_ovf, wb_flag_carry, wb_flag_zero};
            end
            if (w_ovf_set) begin
                r_sb_overflow <= 1'b1;
            end
        end
    end

    logic       w_dec1, w_dec2;
    logic [1:0] w_pend1, w_pend2;
    logic       w_haz1, w_haz2;

    assign w_dec1  = wb_we && (wb_rd_addr == id_rs1_addr);
    assign w_dec2  = wb_we && (wb_rd_addr == id_rs2_addr);

    assign id_rs1_data = f_is_r0(id_rs1_addr) ? '0 :
                         w_dec1 ? wb_alu_result : r_regs[id_rs1_addr];
    assign id_rs2_data = f_is_r0(id_rs2_addr) ? '0 :
                         w_dec2 ? wb_alu_result : r_regs[id_rs2_addr];

    assign id_flags = wb_flags_we ? {wb_flag_ovf, wb_flag_carry, wb_flag_zero} : r_flags;

    // A single outstanding writer that commits this cycle is covered by the bypass.
    assign w_pend1 = r_pend[id_rs1_addr];
    assign w_pend2 = r_pend[id_rs2_addr];
    assign w_haz1  = !f_is_r0(id_rs1_addr) &&
                     ((w_pend1 > 2'd1) || ((w_pend1 == 2'd1) && !w_dec1));
    assign w_haz2  = !f_is_r0(id_rs2_addr) &&
                     ((w_pend2 > 2'd1) || ((w_pend2 == 2'd1) && !w_dec2));

    assign hz_stall    = w_haz1 | w_haz2;
    assign sb_overflow = r_sb_overflow;

endmodule

`default_nettype wire
